// File: rtl/uart_tx_stream.sv
// uart_tx_stream: byte-stream UART transmitter (8N1) fronted by a
// power-of-two byte FIFO. A byte is popped from the FIFO into the shifter
// from IDLE, or on the last STOP cycle so that queued frames follow each
// other with no idle gap.
module uart_tx_stream #(
    parameter int unsigned CLKS_PER_BIT = 1736,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [7:0]                      tx_bus,
    input  logic                            tx_bus_valid,
    output logic                            tx_bus_ready,
    output logic                            tx,
    output logic                            tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          push;
    logic          pop;
    logic          baud_done;

    state_t        state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          tx_r;
    logic          busy_r;

    // Handshake and pop decode; ready never looks at valid
    always_comb begin
        full         = (count == COUNT_FULL);
        tx_bus_ready = !full && !rst;
        push         = tx_bus_valid && tx_bus_ready;
        baud_done    = (baud == BAUD_LAST);
        pop          = (count != '0) &&
                       ((state == IDLE) || ((state == STOP) && baud_done));
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_bus;
        end
    end

    // FIFO pointers and occupancy; simultaneous push/pop leaves count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Frame FSM with registered line and busy outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx_r    <= 1'b1;
                    baud    <= '0;
                    bit_idx <= '0;
                    if (pop) begin
                        shift  <= mem[rd_ptr];
                        state  <= START;
                        tx_r   <= 1'b0;
                        busy_r <= 1'b1;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx_r    <= shift[0];
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx_r  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_r    <= shift[bit_idx + 3'd1];
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            state <= START;
                            tx_r  <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            tx_r   <= 1'b1;
                            busy_r <= 1'b0;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_r   <= 1'b1;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Output mapping
    always_comb begin
        tx         = tx_r;
        tx_busy    = busy_r;
        fifo_count = count;
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// tb_uart_tx_stream: scoreboard bench. Accepted bytes are queued by a
// handshake logger; a line monitor decodes each 40-cycle frame and compares
// it bit-for-bit (and busy) against the queue head.
module tb_uart_tx_stream;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned FLEN  = 10 * CPB;

    logic       clk;
    logic       rst;
    logic [7:0] tx_bus;
    logic       tx_bus_valid;
    logic       tx_bus_ready;
    logic       tx;
    logic       tx_busy;
    logic [4:0] fifo_count;

    uart_tx_stream #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_bus       (tx_bus),
        .tx_bus_valid (tx_bus_valid),
        .tx_bus_ready (tx_bus_ready),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .fifo_count   (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  exp_q[$];
    int unsigned acc_cnt = 0;
    int unsigned rst_epoch = 0;
    int unsigned frames_ok = 0;
    bit          in_frame = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Handshake logger: record every accepted byte, flush on reset
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            rst_epoch++;
        end else if (tx_bus_valid && tx_bus_ready) begin
            exp_q.push_back(tx_bus);
            acc_cnt++;
        end
    end

    // Line monitor: capture a whole frame from its first low sample
    int unsigned seen_epoch = 0;
    int unsigned pos = 0;
    logic [39:0] samp;
    logic [39:0] expv;
    logic [7:0]  e;
    logic [7:0]  gb;
    bit          busy_ok;
    always @(negedge clk) begin
        if (seen_epoch != rst_epoch) begin
            seen_epoch = rst_epoch;
            in_frame   = 0;
        end else begin
            if (!in_frame && tx === 1'b0) begin
                in_frame = 1;
                pos      = 0;
                busy_ok  = 1;
                samp     = '1;
            end
            if (in_frame) begin
                samp[pos] = tx;
                if (tx_busy !== 1'b1) busy_ok = 0;
                pos++;
                if (pos == FLEN) begin
                    in_frame = 0;
                    for (int b = 0; b < 8; b++) gb[b] = samp[4 + 4*b + 2];
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL frame_unexpected: got byte %h, required no frame", gb);
                    end else begin
                        e = exp_q.pop_front();
                        for (int k = 0; k < 40; k++)
                            expv[k] = (k < 4) ? 1'b0 : (k >= 36) ? 1'b1 : e[(k-4)/4];
                        if (samp !== expv || !busy_ok) begin
                            fails++;
                            $display("FAIL frame: got byte %h line %h busy_ok %0d, required byte %h line %h busy_ok 1",
                                     gb, samp, busy_ok, e, expv);
                        end else begin
                            frames_ok++;
                        end
                    end
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        int unsigned t = 0;
        tx_bus       = b;
        tx_bus_valid = 1'b1;
        while (!tx_bus_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!tx_bus_ready) begin
            chk("push_timeout", 32'(tx_bus_ready), 1);
            tx_bus_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            tx_bus_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input int unsigned lim);
        int unsigned t = 0;
        while ((exp_q.size() != 0 || tx_busy || in_frame) && t < lim) begin
            @(negedge clk);
            t++;
        end
        chk("drain_in_time", 32'(t < lim), 1);
    endtask

    // Watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          run;
    int          first_low;
    int unsigned a0;
    int unsigned bcnt;

    initial begin
        rst          = 1'b1;
        tx_bus       = '0;
        tx_bus_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_tx", 32'(tx), 1);
        chk("rst_busy", 32'(tx_busy), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_ready", 32'(tx_bus_ready), 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(tx_bus_ready), 1);
        @(negedge clk);

        // Single byte 0x55: latency and 40-cycle busy window
        push_byte(8'h55);
        chk("lat_tx_edgeE", 32'(tx), 1);
        chk("lat_count_edgeE", 32'(fifo_count), 1);
        @(negedge clk);
        chk("lat_tx_edgeE1", 32'(tx), 0);
        chk("lat_busy_edgeE1", 32'(tx_busy), 1);
        run = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!tx_busy) break;
            run++;
        end
        chk("single_busy_cycles", 32'(run), 40);
        chk("single_idle_tx", 32'(tx), 1);
        wait_drain(200);

        // Back-to-back 0x41, 0x42: one contiguous 80-cycle busy window
        push_byte(8'h41);
        push_byte(8'h42);
        run = tx_busy ? 1 : 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!tx_busy) break;
            run++;
        end
        chk("b2b_busy_cycles", 32'(run), 80);
        wait_drain(200);

        // Fill: valid held 30 cycles with incrementing data
        a0        = acc_cnt;
        first_low = -1;
        tx_bus_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tx_bus = 8'(i);
            @(posedge clk);
            @(negedge clk);
            if (!tx_bus_ready && first_low < 0) first_low = i;
            if (i == 16) chk("full_count", 32'(fifo_count), 16);
        end
        tx_bus_valid = 1'b0;
        chk("full_first_not_ready", 32'(first_low), 16);
        chk("full_accepted", acc_cnt - a0, 17);
        wait_drain(2000);

        // Reset during data bit 3 with bytes queued
        for (int k = 0; k < 5; k++) push_byte(8'hA0 + 8'(k));
        chk("rstmid_count", 32'(fifo_count), 4);
        repeat (13) @(negedge clk);
        chk("rstmid_busy_before", 32'(tx_busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_tx", 32'(tx), 1);
        chk("rstmid_busy", 32'(tx_busy), 0);
        chk("rstmid_count0", 32'(fifo_count), 0);
        chk("rstmid_ready_in_rst", 32'(tx_bus_ready), 0);
        rst = 1'b0;
        #1;
        chk("rstmid_ready_after", 32'(tx_bus_ready), 1);
        bcnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_busy) bcnt++;
        end
        chk("rstmid_no_frames", bcnt, 0);

        // Push coinciding with the pop on the last STOP cycle
        tx_bus_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tx_bus = 8'h10 + 8'(j);
            @(posedge clk);
            @(negedge clk);
        end
        tx_bus_valid = 1'b0;
        chk("simul_pre_count", 32'(fifo_count), 3);
        repeat (37) @(negedge clk);
        chk("simul_stop_count", 32'(fifo_count), 3);
        chk("simul_stop_tx", 32'(tx), 1);
        tx_bus       = 8'h14;
        tx_bus_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_bus_valid = 1'b0;
        chk("simul_count", 32'(fifo_count), 3);
        chk("simul_restart_tx", 32'(tx), 0);
        wait_drain(1000);

        // Stream of random bytes with random gaps
        for (int k = 0; k < 256; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push_byte(8'($urandom_range(0, 255)));
        end
        wait_drain(20000);

        chk("frames_total", frames_ok, 1 + 2 + 17 + 5 + 256);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
